task_sequencer: RTL and testbench
=================================

# task_sequencer

Parametrised Moore sequencer that runs up to NUM_STAGES sub-tasks in order, using a start-pulse/done handshake for each stage. It generalises the fixed three-stage a/b/c controller. New behaviour: a per-run stage skip mask, a per-stage watchdog timeout, an abort input, and error reporting. The block sits between a host control bit and the sub-task engines, and it owns the run order.

## Interface
- NUM_STAGES, 3, number of stages (1..16)
- TIMEOUT, 255, maximum WAIT cycles per stage; 0 disables the watchdog
- TO_W, 8, watchdog counter width; TIMEOUT must fit in TO_W bits
- IDX_W, 4, stage index width; must satisfy 2^IDX_W ≥ NUM_STAGES
- clk  in  1  single clock, rising edge
- reset_n  in  1  asynchronous active-low reset
- start  in  1  level; sampled only in IDLE
- skip_mask  in  NUM_STAGES  bit k=1 skips stage k; captured together with start
- abort  in  1  terminates the run from any non-IDLE state
- stage_done  in  NUM_STAGES  completion from each engine; only the active stage's bit is honoured
- stage_start  out  NUM_STAGES  one-hot, 1-cycle start pulse to the active stage
- busy  out  1  high in every state except IDLE
- stage_idx  out  IDX_W  index of the active stage; 0 in IDLE
- done  out  1  1-cycle pulse on successful completion
- error  out  1  1-cycle pulse on timeout or abort
- err_code  out  2  00 none, 01 timeout, 10 abort; held until the next accepted start
- err_stage  out  IDX_W  stage active when the error occurred; held like err_code

## Operation
- States: IDLE, START, WAIT, DONE, ERROR. All outputs are registered and depend only on state and registers (Moore).
- Reset (asynchronous assert, synchronous release): state=IDLE. All outputs are 0, the captured mask is 0, and the watchdog counter is 0.
- IDLE, start=1:
  - Capture skip_mask.
  - Clear err_code and err_stage.
  - Go to START with the lowest non-skipped stage.
  - If every stage is skipped, go directly to DONE.
- START: assert stage_start[stage_idx] for this single cycle, clear the watchdog, then go to WAIT.
- WAIT, stage_done[stage_idx]=1: go to START with the next higher non-skipped stage. If no such stage remains, go to DONE.
- WAIT with no done, TIMEOUT≠0 and counter==TIMEOUT-1: go to ERROR with err_code=01. Otherwise the counter increments each cycle.
- abort=1 in START, WAIT or DONE: go to ERROR with err_code=10 and err_stage=stage_idx. Abort in IDLE or ERROR is ignored.
- DONE: done=1 for one cycle, then IDLE.
- ERROR: error=1 for one cycle, then IDLE.
- Priority within one cycle: abort > stage_done > timeout.
- stage_done bits of non-active stages, and any stage_done outside WAIT, are ignored.
- start is ignored while busy. A start still held high in the IDLE cycle after DONE or ERROR launches a new run.

## Timing
- Start is sampled at edge E0. START of the first stage is visible in cycle 1.
- Each stage costs at least 2 cycles: START plus at least one WAIT.
- With all done inputs answered in the first WAIT cycle, done is high in cycle 2·Nactive+1. Examples: NUM_STAGES=3 with no skips gives cycle 7; all stages skipped gives cycle 1.
- Watchdog: with TIMEOUT=T, a stage whose done is still absent after T WAIT cycles enters ERROR. error is high in the cycle after the T-th WAIT cycle. A done arriving in that T-th cycle is accepted.
- After an abort is sampled, error is high in the next cycle. busy falls one cycle after that.
- Asserting reset_n low mid-run clears everything immediately, with no done or error pulse. stage_start drops combinationally with the register clear.
- skip_mask changes after capture have no effect on the run in progress.

## Test plan
- NUM_STAGES=3, skip_mask=000, each stage_done returned 1 cycle after its stage_start → stage_start pulses 001, 010, 100 in cycles 1, 3, 5; done=1 in cycle 7; busy high in cycles 1–7.
- skip_mask=010 → stage_start pulses only 001 and 100; stage_idx goes 0 then 2; done in cycle 5. skip_mask=111 → done in cycle 1, and stage_start never pulses.
- TIMEOUT=4, stage 1 never returns done → 4 WAIT cycles, then error=1 with err_code=01 and err_stage=1; done never pulses. The next start clears err_code to 00.
- abort asserted during stage 2 WAIT, together with stage_done[2]=1 → ERROR with err_code=10 and err_stage=2; abort wins; no done pulse.
- stage_done[2] pulsed while stage 0 is active, and again in IDLE → ignored; the sequence and timing are unchanged.
- reset_n pulsed low in stage 1 WAIT → all outputs are 0 immediately; the block is in IDLE after release; a fresh start produces a normal cycle-7 done.

Source files
------------

// File: rtl/task_sequencer.sv
// Moore sequencer that runs up to NUM_STAGES sub-tasks in order with a start/done handshake,
// per-run skip mask, per-stage watchdog, abort input and latched error reporting.
module task_sequencer #(
   parameter int NUM_STAGES = 3,
   parameter int TIMEOUT    = 255,
   parameter int TO_W       = 8,
   parameter int IDX_W      = 4
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic                  start,
   input  logic [NUM_STAGES-1:0] skip_mask,
   input  logic                  abort,
   input  logic [NUM_STAGES-1:0] stage_done,
   output logic [NUM_STAGES-1:0] stage_start,
   output logic                  busy,
   output logic [IDX_W-1:0]      stage_idx,
   output logic                  done,
   output logic                  error,
   output logic [1:0]            err_code,
   output logic [IDX_W-1:0]      err_stage
);

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_START = 3'd1;
   localparam logic [2:0] S_WAIT  = 3'd2;
   localparam logic [2:0] S_DONE  = 3'd3;
   localparam logic [2:0] S_ERROR = 3'd4;

   localparam logic [1:0] ERR_NONE    = 2'b00;
   localparam logic [1:0] ERR_TIMEOUT = 2'b01;
   localparam logic [1:0] ERR_ABORT   = 2'b10;

   localparam bit             WD_EN   = (TIMEOUT != 0);
   localparam logic [TO_W-1:0] WD_LAST = TO_W'(TIMEOUT - 1);

   // Lowest non-skipped stage at or above lo; MSB of the result flags that one exists.
   function automatic logic [IDX_W:0] next_stage(input logic [NUM_STAGES-1:0] mask, input int lo);
      logic [IDX_W:0] r;
      r = '0;
      for (int k = NUM_STAGES - 1; k >= 0; k--) begin
         if (!mask[k] && (k >= lo)) begin
            r = {1'b1, IDX_W'(k)};
         end else begin
            r = r;
         end
      end
      return r;
   endfunction

   logic [2:0]            state_q, state_d;
   logic [IDX_W-1:0]      idx_q, idx_d;
   logic [NUM_STAGES-1:0] mask_q, mask_d;
   logic [TO_W-1:0]       wd_q, wd_d;
   logic [1:0]            ec_q, ec_d;
   logic [IDX_W-1:0]      es_q, es_d;
   logic [NUM_STAGES-1:0] ss_q;
   logic                  busy_q, done_q, error_q;
   logic [IDX_W:0]        nxt_s;

   // Next-state logic; abort outranks stage_done, which outranks the watchdog.
   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      mask_d  = mask_q;
      wd_d    = wd_q;
      ec_d    = ec_q;
      es_d    = es_q;
      nxt_s   = '0;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               mask_d = skip_mask;
               ec_d   = ERR_NONE;
               es_d   = '0;
               nxt_s  = next_stage(skip_mask, 0);
               if (nxt_s[IDX_W]) begin
                  state_d = S_START;
                  idx_d   = nxt_s[IDX_W-1:0];
               end else begin
                  state_d = S_DONE;
                  idx_d   = '0;
               end
            end else begin
               state_d = S_IDLE;
            end
         end
         S_START: begin
            wd_d = '0;
            if (abort) begin
               state_d = S_ERROR;
               ec_d    = ERR_ABORT;
               es_d    = idx_q;
            end else begin
               state_d = S_WAIT;
            end
         end
         S_WAIT: begin
            if (abort) begin
               state_d = S_ERROR;
               ec_d    = ERR_ABORT;
               es_d    = idx_q;
            end else if (stage_done[idx_q]) begin
               nxt_s = next_stage(mask_q, int'(idx_q) + 1);
               if (nxt_s[IDX_W]) begin
                  state_d = S_START;
                  idx_d   = nxt_s[IDX_W-1:0];
               end else begin
                  state_d = S_DONE;
               end
            end else if (WD_EN && (wd_q == WD_LAST)) begin
               state_d = S_ERROR;
               ec_d    = ERR_TIMEOUT;
               es_d    = idx_q;
            end else begin
               wd_d = wd_q + TO_W'(1);
            end
         end
         S_DONE: begin
            if (abort) begin
               state_d = S_ERROR;
               ec_d    = ERR_ABORT;
               es_d    = idx_q;
            end else begin
               state_d = S_IDLE;
               idx_d   = '0;
            end
         end
         S_ERROR: begin
            state_d = S_IDLE;
            idx_d   = '0;
         end
         default: begin
            state_d = S_IDLE;
            idx_d   = '0;
         end
      endcase
   end

   // State and output registers; outputs are decoded from the next state so they track state_q.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= S_IDLE;
         idx_q   <= '0;
         mask_q  <= '0;
         wd_q    <= '0;
         ec_q    <= ERR_NONE;
         es_q    <= '0;
         ss_q    <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         error_q <= 1'b0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         mask_q  <= mask_d;
         wd_q    <= wd_d;
         ec_q    <= ec_d;
         es_q    <= es_d;
         ss_q    <= (state_d == S_START) ? (NUM_STAGES'(1'b1) << idx_d) : '0;
         busy_q  <= (state_d != S_IDLE);
         done_q  <= (state_d == S_DONE);
         error_q <= (state_d == S_ERROR);
      end
   end

   assign stage_start = ss_q;
   assign busy        = busy_q;
   assign stage_idx   = idx_q;
   assign done        = done_q;
   assign error       = error_q;
   assign err_code    = ec_q;
   assign err_stage   = es_q;

endmodule

// File: tb/tb_task_sequencer.sv
// Randomized bench for task_sequencer: a cycle-table model derived from the run rules predicts
// every output cycle by cycle and also schedules the stage_done/abort stimulus.
module tb_task_sequencer;

   localparam int NS = 3;
   localparam int T  = 4;
   localparam int IW = 4;

   localparam int K_START = 0;
   localparam int K_WAIT  = 1;
   localparam int K_DONE  = 2;
   localparam int K_ERR   = 3;

   logic          clk = 1'b0;
   logic          reset_n;
   logic          start;
   logic [NS-1:0] skip_mask;
   logic          abort;
   logic [NS-1:0] stage_done;
   logic [NS-1:0] stage_start;
   logic          busy;
   logic [IW-1:0] stage_idx;
   logic          done;
   logic          error;
   logic [1:0]    err_code;
   logic [IW-1:0] err_stage;

   task_sequencer #(.NUM_STAGES(NS), .TIMEOUT(T), .TO_W(8), .IDX_W(IW)) dut (
      .clk(clk), .reset_n(reset_n), .start(start), .skip_mask(skip_mask), .abort(abort),
      .stage_done(stage_done), .stage_start(stage_start), .busy(busy), .stage_idx(stage_idx),
      .done(done), .error(error), .err_code(err_code), .err_stage(err_stage)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [1:0]    kind;
      logic [IW-1:0] idx;
      logic          idx_chk;
      logic [NS-1:0] ss;
      logic          dn;
      logic          er;
      logic [1:0]    ec;
      logic [IW-1:0] es;
      logic [NS-1:0] drv_done;
      logic          drv_abort;
      logic [NS-1:0] act;
   } row_t;

   row_t          rows[$];
   int            dly[NS];
   logic [1:0]    ref_ec = 2'b00;
   logic [IW-1:0] ref_es = '0;
   int            n_chk  = 0;
   int            n_pass = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
   endtask

   function automatic row_t mk(input int kind, input int k, input bit ab);
      row_t r;
      r           = '0;
      r.kind      = 2'(kind);
      r.idx       = IW'(k);
      r.idx_chk   = (kind == K_START) || (kind == K_WAIT);
      r.dn        = (kind == K_DONE);
      r.drv_abort = ab;
      return r;
   endfunction

   task automatic add_err(input int k, input logic [1:0] code);
      row_t r;
      r    = mk(K_ERR, k, 1'b0);
      r.er = 1'b1;
      r.ec = code;
      r.es = IW'(k);
      rows.push_back(r);
      ref_ec = code;
      ref_es = IW'(k);
   endtask

   // Expected trace of one run from cycle 1 onward; ab is the cycle in which abort is held (-1: none).
   task automatic build(input logic [NS-1:0] m, input int ab);
      int   cyc;
      int   last;
      bit   fin;
      row_t r;
      rows.delete();
      ref_ec = 2'b00;
      ref_es = '0;
      cyc  = 1;
      last = 0;
      fin  = 1'b0;
      for (int k = 0; k < NS && !fin; k++) begin
         if (m[k]) continue;
         last = k;
         r    = mk(K_START, k, ab == cyc);
         r.ss = NS'(1) << k;
         rows.push_back(r);
         if (ab == cyc) begin
            add_err(k, 2'b10);
            fin = 1'b1;
         end
         cyc++;
         for (int w = 1; !fin; w++) begin
            r     = mk(K_WAIT, k, ab == cyc);
            r.act = NS'(1) << k;
            if (w == dly[k]) r.drv_done = NS'(1) << k;
            rows.push_back(r);
            if (ab == cyc) begin
               add_err(k, 2'b10);
               fin = 1'b1;
            end else if (w == dly[k]) begin
               cyc++;
               break;
            end else if (w == T) begin
               add_err(k, 2'b01);
               fin = 1'b1;
            end else begin
               cyc++;
            end
         end
      end
      if (!fin) begin
         rows.push_back(mk(K_DONE, last, ab == cyc));
         if (ab == cyc) add_err(last, 2'b10);
      end
   endtask

   task automatic check_idle(input string tag);
      chk({tag, ".busy"}, 32'(busy), 32'd0);
      chk({tag, ".stage_start"}, 32'(stage_start), 32'd0);
      chk({tag, ".stage_idx"}, 32'(stage_idx), 32'd0);
      chk({tag, ".done"}, 32'(done), 32'd0);
      chk({tag, ".error"}, 32'(error), 32'd0);
      chk({tag, ".err_code"}, 32'(err_code), 32'(ref_ec));
      chk({tag, ".err_stage"}, 32'(err_stage), 32'(ref_es));
   endtask

   task automatic drive_idle(input bit st, input logic [NS-1:0] m);
      start      = st;
      skip_mask  = m;
      abort      = 1'($urandom_range(0, 1));
      stage_done = NS'($urandom & $urandom);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Check and drive up to n rows of the current trace, one clock per row.
   task automatic run_rows(input string tag, input int n);
      row_t r;
      for (int i = 0; i < rows.size() && i < n; i++) begin
         r = rows[i];
         chk($sformatf("%s.c%0d.busy", tag, i + 1), 32'(busy), 32'd1);
         chk($sformatf("%s.c%0d.stage_start", tag, i + 1), 32'(stage_start), 32'(r.ss));
         chk($sformatf("%s.c%0d.done", tag, i + 1), 32'(done), 32'(r.dn));
         chk($sformatf("%s.c%0d.error", tag, i + 1), 32'(error), 32'(r.er));
         chk($sformatf("%s.c%0d.err_code", tag, i + 1), 32'(err_code), 32'(r.ec));
         chk($sformatf("%s.c%0d.err_stage", tag, i + 1), 32'(err_stage), 32'(r.es));
         if (r.idx_chk) chk($sformatf("%s.c%0d.stage_idx", tag, i + 1), 32'(stage_idx), 32'(r.idx));
         start      = 1'($urandom_range(0, 1));
         skip_mask  = NS'($urandom);
         stage_done = r.drv_done | (NS'($urandom & $urandom) & ~r.act);
         abort      = r.drv_abort | ((int'(r.kind) == K_ERR) && ($urandom_range(0, 1) == 1));
         step();
      end
   endtask

   task automatic do_run(input string tag, input logic [NS-1:0] m, input int ab, input int gap);
      for (int g = 0; g < gap; g++) begin
         check_idle({tag, ".gap"});
         drive_idle(1'b0, NS'($urandom));
         step();
      end
      check_idle({tag, ".idle"});
      drive_idle(1'b1, m);
      build(m, ab);
      step();
      run_rows(tag, 1000);
   endtask

   initial begin
      reset_n    = 1'b0;
      start      = 1'b0;
      skip_mask  = '0;
      abort      = 1'b0;
      stage_done = '0;
      #3;
      check_idle("reset");
      #9 reset_n = 1'b1;
      step();

      dly = '{1, 1, 1};   do_run("all3", 3'b000, -1, 1);
      dly = '{1, 1, 1};   do_run("skip010", 3'b010, -1, 0);
      dly = '{1, 1, 1};   do_run("skip111", 3'b111, -1, 0);
      dly = '{1, 99, 1};  do_run("timeout1", 3'b000, -1, 0);
      dly = '{1, 1, 1};   do_run("abort_vs_done", 3'b000, 6, 1);
      dly = '{4, 2, 4};   do_run("done_at_limit", 3'b000, -1, 0);
      dly = '{1, 1, 1};   do_run("abort_in_done", 3'b000, 7, 0);
      dly = '{2, 1, 1};   do_run("abort_in_start", 3'b000, 1, 0);
      dly = '{1, 1, 1};   do_run("abort_skipall", 3'b111, 1, 0);

      // Reset during stage 1 WAIT: everything clears at once, then a fresh run behaves normally.
      dly = '{1, 99, 1};
      check_idle("rst.idle");
      drive_idle(1'b1, 3'b000);
      build(3'b000, -1);
      step();
      run_rows("rst", 4);
      start      = 1'b0;
      abort      = 1'b0;
      stage_done = '0;
      #2 reset_n = 1'b0;
      ref_ec = 2'b00;
      ref_es = '0;
      #1 check_idle("rst.mid");
      #3 reset_n = 1'b1;
      step();
      dly = '{1, 1, 1};   do_run("after_rst", 3'b000, -1, 0);

      for (int n = 0; n < 30; n++) begin
         for (int k = 0; k < NS; k++) dly[k] = $urandom_range(1, 6);
         do_run($sformatf("rnd%0d", n), NS'($urandom),
                ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, 16)) : -1,
                $urandom_range(0, 2));
      end

      check_idle("final");
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
